// File: rtl/servo_pwm_scheduler.sv
// rtl/servo_pwm_scheduler.sv - servo PWM generator with frame-atomic commit and per-frame slew limit
module servo_pwm_scheduler #(
   parameter int NUM_CH     = 20,
   parameter int CLK_DIV    = 50,
   parameter int CNT_W      = 16,
   parameter int DEF_PERIOD = 20000,
   parameter int MIN_PW     = 500,
   parameter int MAX_PW     = 2500
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_irq
);

   localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic              r_enable;
   logic              r_auto;
   logic              r_pending;
   logic [CNT_W-1:0]  r_period;
   logic [CNT_W-1:0]  r_step;
   logic [PS_W-1:0]   r_presc;
   logic [CNT_W-1:0]  r_frame_cnt;
   logic [15:0]       r_frame_num;
   logic [31:0]       r_readdata;
   logic [NUM_CH-1:0] r_pwm;
   logic              r_irq;
   logic [CNT_W-1:0]  r_shadow [NUM_CH];
   logic [CNT_W-1:0]  r_target [NUM_CH];
   logic [CNT_W-1:0]  r_active [NUM_CH];

   logic              w_wr_ctrl;
   logic              w_wr_period;
   logic              w_wr_step;
   logic              w_wr_sh;
   logic              w_tick;
   logic              w_boundary;
   logic              w_set_pending;
   logic [CNT_W-1:0]  w_clamped;
   logic [CNT_W-1:0]  w_period_val;
   logic [31:0]       w_rd_mux;
   logic [CNT_W-1:0]  w_t    [NUM_CH];
   logic [CNT_W-1:0]  w_d    [NUM_CH];
   logic [CNT_W-1:0]  w_mv   [NUM_CH];
   logic [CNT_W-1:0]  w_next [NUM_CH];

   assign w_wr_ctrl   = avs_write && (avs_address == 6'h00);
   assign w_wr_period = avs_write && (avs_address == 6'h02);
   assign w_wr_step   = avs_write && (avs_address == 6'h03);
   assign w_wr_sh     = avs_write && avs_address[5] && (int'(avs_address[4:0]) < NUM_CH);

   // A zero period would never wrap, so it is stored as the shortest legal frame
   assign w_period_val = (avs_writedata[CNT_W-1:0] == '0) ? CNT_W'(1) : avs_writedata[CNT_W-1:0];

   assign w_tick     = r_enable && (r_presc == PS_W'(CLK_DIV - 1));
   // ">=" lets a period shrunk below the current count wrap on the very next tick
   assign w_boundary = w_tick && (r_frame_cnt >= (r_period - CNT_W'(1)));

   // A request arriving on a boundary cycle wins over the clear, so it lands next frame
   assign w_set_pending = (w_wr_ctrl && avs_writedata[1]) || (w_wr_sh && r_auto);

   assign avs_readdata = r_readdata;
   assign pwm_out      = r_pwm;
   assign frame_irq    = r_irq;

   // Shadow write value: zero switches the channel off, anything else is clamped to the servo range
   always_comb begin
      w_clamped = avs_writedata[CNT_W-1:0];
      if (avs_writedata == 32'd0)
         w_clamped = '0;
      else if (avs_writedata < 32'(MIN_PW))
         w_clamped = CNT_W'(MIN_PW);
      else if (avs_writedata > 32'(MAX_PW))
         w_clamped = CNT_W'(MAX_PW);
   end

   // Register readback mux; unmapped words and absent channels read as zero
   always_comb begin
      w_rd_mux = '0;
      case (avs_address)
         6'h00:   w_rd_mux = {29'd0, r_auto, 1'b0, r_enable};
         6'h01:   w_rd_mux = {r_frame_num, 14'd0, r_enable, r_pending};
         6'h02:   w_rd_mux[CNT_W-1:0] = r_period;
         6'h03:   w_rd_mux[CNT_W-1:0] = r_step;
         default: begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (avs_address == 6'(32 + n))
                  w_rd_mux[CNT_W-1:0] = r_shadow[n];
            end
         end
      endcase
   end

   // Per-channel boundary update: pick the new target, then slew active toward it without underflow
   always_comb begin
      for (int n = 0; n < NUM_CH; n++) begin
         w_t[n]  = r_pending ? r_shadow[n] : r_target[n];
         w_d[n]  = (w_t[n] > r_active[n]) ? (w_t[n] - r_active[n]) : (r_active[n] - w_t[n]);
         w_mv[n] = (r_step < w_d[n]) ? r_step : w_d[n];
         if ((r_step == '0) || (w_t[n] == '0) || (r_active[n] == '0))
            w_next[n] = w_t[n];
         else if (w_t[n] > r_active[n])
            w_next[n] = r_active[n] + w_mv[n];
         else
            w_next[n] = r_active[n] - w_mv[n];
      end
   end

   // Control/config registers and the commit-pending flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_enable  <= 1'b0;
         r_auto    <= 1'b0;
         r_pending <= 1'b0;
         r_period  <= CNT_W'(DEF_PERIOD);
         r_step    <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_enable <= avs_writedata[0];
            r_auto   <= avs_writedata[2];
         end
         if (w_wr_period)
            r_period <= w_period_val;
         if (w_wr_step)
            r_step <= avs_writedata[CNT_W-1:0];
         if (w_set_pending)
            r_pending <= 1'b1;
         else if (w_boundary)
            r_pending <= 1'b0;
      end
   end

   // Registered read data, one clock after the read strobe
   always_ff @(posedge clk) begin
      if (reset)
         r_readdata <= '0;
      else if (avs_read)
         r_readdata <= w_rd_mux;
   end

   // Microsecond prescaler, frame counter and frame number; all idle at zero while disabled
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc     <= '0;
         r_frame_cnt <= '0;
         r_frame_num <= '0;
      end else if (!r_enable) begin
         r_presc     <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_presc <= w_tick ? '0 : (r_presc + PS_W'(1));
         if (w_tick)
            r_frame_cnt <= w_boundary ? '0 : (r_frame_cnt + CNT_W'(1));
         if (w_boundary)
            r_frame_num <= r_frame_num + 16'd1;
      end
   end

   // Software-visible shadow widths
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < NUM_CH; n++)
            r_shadow[n] <= '0;
      end else begin
         for (int n = 0; n < NUM_CH; n++) begin
            if (w_wr_sh && (avs_address == 6'(32 + n)))
               r_shadow[n] <= w_clamped;
         end
      end
   end

   // Target/active widths change only on a frame boundary; the commit raises the irq for one clock
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq <= 1'b0;
         for (int n = 0; n < NUM_CH; n++) begin
            r_target[n] <= '0;
            r_active[n] <= '0;
         end
      end else begin
         r_irq <= w_boundary && r_pending;
         if (w_boundary) begin
            for (int n = 0; n < NUM_CH; n++) begin
               r_target[n] <= w_t[n];
               r_active[n] <= w_next[n];
            end
         end
      end
   end

   // Pulse outputs, registered one clock behind the frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pwm <= '0;
      end else begin
         for (int n = 0; n < NUM_CH; n++)
            r_pwm[n] <= r_enable && (r_frame_cnt < r_active[n]);
      end
   end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// tb/tb_servo_pwm_scheduler.sv - self-checking bench for servo_pwm_scheduler
module tb_servo_pwm_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  addr = '0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [31:0] wd = '0;
   logic [31:0] a_rdata, b_rdata;
   logic [3:0]  a_pwm;
   logic [19:0] b_pwm;
   logic        a_irq, b_irq;

   int          n_vec = 0;
   int          n_err = 0;
   bit          sel_b = 1'b1;
   bit          mon_on = 1'b0;
   int          run = 0;
   int          pq[$];
   logic [31:0] rdq[$];

   typedef struct {
      int          kind;
      logic [5:0]  a;
      logic [31:0] d;
      logic [31:0] e;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   servo_pwm_scheduler #(
      .NUM_CH(4), .CLK_DIV(2), .CNT_W(16), .DEF_PERIOD(20000), .MIN_PW(1), .MAX_PW(2500)
   ) u_a (
      .clk(clk), .reset(reset), .avs_address(addr), .avs_write(wr), .avs_writedata(wd),
      .avs_read(rd), .avs_readdata(a_rdata), .pwm_out(a_pwm), .frame_irq(a_irq)
   );

   servo_pwm_scheduler #(
      .NUM_CH(20), .CLK_DIV(2), .CNT_W(16), .DEF_PERIOD(20000), .MIN_PW(500), .MAX_PW(2500)
   ) u_b (
      .clk(clk), .reset(reset), .avs_address(addr), .avs_write(wr), .avs_writedata(wd),
      .avs_read(rd), .avs_readdata(b_rdata), .pwm_out(b_pwm), .frame_irq(b_irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   // kind 0 = write, 1 = read, 2 = write and read together
   task automatic bus(input int kind, input logic [5:0] a, input logic [31:0] d, input logic [31:0] e);
      logic [31:0] x;
      @(negedge clk);
      addr = a;
      wd   = d;
      wr   = (kind != 1);
      rd   = (kind != 0);
      if (kind != 0) rdq.push_back(e);
      @(negedge clk);
      wr = 1'b0;
      rd = 1'b0;
      if (kind != 0) begin
         x = rdq.pop_front();
         check($sformatf("read 0x%0h", a), sel_b ? b_rdata : a_rdata, x);
      end
   endtask

   task automatic wait_irq(input int lim, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!a_irq && k < lim);
   endtask

   task automatic wait_q(input int lim, input string name);
      int k = 0;
      while (pq.size() > 0 && k < lim) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(pq.size()), 32'd0);
      pq.delete();
   endtask

   // Pulse scoreboard on channel 0 of the small instance
   initial begin
      forever begin
         @(negedge clk);
         if (a_pwm[0]) begin
            run++;
         end else begin
            if (run > 0 && mon_on && pq.size() > 0)
               check("pulse width ch0", 32'(run), 32'(pq.pop_front()));
            run = 0;
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int hi;

      tbl.push_back('{1, 6'h02, 32'd0,     32'd20000});
      tbl.push_back('{1, 6'h01, 32'd0,     32'd0});
      tbl.push_back('{1, 6'h00, 32'd0,     32'd0});
      tbl.push_back('{1, 6'h03, 32'd0,     32'd0});
      tbl.push_back('{0, 6'h21, 32'd100,   32'd0});
      tbl.push_back('{1, 6'h21, 32'd0,     32'd500});
      tbl.push_back('{0, 6'h21, 32'd9000,  32'd0});
      tbl.push_back('{1, 6'h21, 32'd0,     32'd2500});
      tbl.push_back('{0, 6'h21, 32'd0,     32'd0});
      tbl.push_back('{1, 6'h21, 32'd0,     32'd0});
      tbl.push_back('{0, 6'h21, 32'd1234,  32'd0});
      tbl.push_back('{1, 6'h21, 32'd0,     32'd1234});
      tbl.push_back('{0, 6'h33, 32'd2500,  32'd0});
      tbl.push_back('{1, 6'h33, 32'd0,     32'd2500});
      tbl.push_back('{0, 6'h34, 32'd700,   32'd0});
      tbl.push_back('{1, 6'h34, 32'd0,     32'd0});
      tbl.push_back('{1, 6'h10, 32'd0,     32'd0});
      tbl.push_back('{0, 6'h02, 32'd0,     32'd0});
      tbl.push_back('{1, 6'h02, 32'd0,     32'd1});
      tbl.push_back('{0, 6'h03, 32'd77,    32'd0});
      tbl.push_back('{2, 6'h03, 32'd55,    32'd77});
      tbl.push_back('{1, 6'h03, 32'd0,     32'd55});
      tbl.push_back('{0, 6'h00, 32'd2,     32'd0});
      tbl.push_back('{1, 6'h01, 32'd0,     32'd1});
      tbl.push_back('{1, 6'h00, 32'd0,     32'd0});
      tbl.push_back('{0, 6'h00, 32'd5,     32'd0});
      tbl.push_back('{1, 6'h00, 32'd0,     32'd5});
      tbl.push_back('{0, 6'h00, 32'd0,     32'd0});

      repeat (3) @(negedge clk);
      check("reset pwm_out", 32'(b_pwm), 32'd0);
      check("reset frame_irq", 32'(b_irq), 32'd0);
      check("reset readdata", b_rdata, 32'd0);
      reset = 1'b0;

      // register map on the full-size instance
      sel_b = 1'b1;
      for (int i = 0; i < tbl.size(); i++)
         bus(tbl[i].kind, tbl[i].a, tbl[i].d, tbl[i].e);

      // timing checks on the small instance
      sel_b = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      bus(0, 6'h02, 32'd10, 32'd0);
      bus(0, 6'h20, 32'd3, 32'd0);
      bus(0, 6'h00, 32'd3, 32'd0);
      wait_irq(100, k);
      check("first commit irq latency", 32'(k), 32'd20);
      @(negedge clk);
      check("irq single cycle", 32'(a_irq), 32'd0);
      bus(1, 6'h01, 32'd0, 32'h0001_0002);
      repeat (20) @(negedge clk);
      bus(1, 6'h01, 32'd0, 32'h0002_0002);
      mon_on = 1'b1;
      pq.push_back(6);
      pq.push_back(6);
      wait_q(200, "pulses width 3");

      // shadow write without commit leaves outputs alone
      bus(0, 6'h20, 32'd5, 32'd0);
      pq.push_back(6);
      pq.push_back(6);
      pq.push_back(6);
      wait_q(200, "no commit 3 frames");

      // auto mode: shadow write commits at the next boundary
      bus(0, 6'h00, 32'd5, 32'd0);
      bus(0, 6'h20, 32'd5, 32'd0);
      pq.push_back(10);
      pq.push_back(10);
      wait_q(200, "auto commit");

      // commit landing on the boundary cycle applies one frame later
      bus(0, 6'h00, 32'd1, 32'd0);
      bus(0, 6'h20, 32'd8, 32'd0);
      k = 0;
      while (!a_pwm[0] && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("rise seen before boundary commit", 32'(a_pwm[0]), 32'd1);
      repeat (18) @(negedge clk);
      addr = 6'h00;
      wd   = 32'd3;
      wr   = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      check("no irq on boundary commit", 32'(a_irq), 32'd0);
      pq.push_back(10);
      pq.push_back(16);
      wait_irq(100, k);
      check("deferred commit irq", 32'(k), 32'd20);
      wait_q(200, "deferred commit pulses");

      // slew limit 200 per frame from 1000 to 1500
      bus(0, 6'h02, 32'd1600, 32'd0);
      bus(0, 6'h20, 32'd1000, 32'd0);
      bus(0, 6'h00, 32'd3, 32'd0);
      wait_irq(4000, k);
      check("slew first commit irq", 32'(a_irq), 32'd1);
      pq.push_back(2000);
      pq.push_back(2400);
      pq.push_back(2800);
      pq.push_back(3000);
      pq.push_back(3000);
      bus(0, 6'h03, 32'd200, 32'd0);
      bus(0, 6'h20, 32'd1500, 32'd0);
      bus(0, 6'h00, 32'd3, 32'd0);
      wait_q(20000, "slew pulses");

      // reset in the middle of a pulse
      mon_on = 1'b0;
      k = 0;
      while (!a_pwm[0] && k < 4000) begin
         @(negedge clk);
         k++;
      end
      check("pulse high before reset", 32'(a_pwm[0]), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("pwm low after reset", 32'(a_pwm), 32'd0);
      check("irq low after reset", 32'(a_irq), 32'd0);
      reset = 1'b0;
      bus(1, 6'h00, 32'd0, 32'd0);
      bus(1, 6'h01, 32'd0, 32'd0);
      bus(1, 6'h02, 32'd0, 32'd20000);
      bus(1, 6'h03, 32'd0, 32'd0);
      bus(1, 6'h20, 32'd0, 32'd0);

      // zero width keeps the channel low even after a commit
      bus(0, 6'h02, 32'd10, 32'd0);
      bus(0, 6'h20, 32'd0, 32'd0);
      bus(0, 6'h00, 32'd3, 32'd0);
      wait_irq(100, k);
      check("zero width commit irq", 32'(k), 32'd20);
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (a_pwm[0]) hi++;
      end
      check("zero width stays low", 32'(hi), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
